vga_embarcacao_param: RTL and testbench

Parametrised successor of the single-cell ship renderer. It draws a ship of 1..MAX_CELULAS cells on the 8x8 board grid of the 640x480 VGA frame. It adds several behaviours the single-cell renderer lacks:
- a load handshake;
- a sequential cell-to-pixel mapper;
- per-cell hit marking with frame-synchronous blinking;
- sunk detection;
- a registered RGB output.

It sits between the game logic (positions, hit mask) and the VGA colour mux, one instance per ship.

---
 rtl/vga_embarcacao_param.sv | 213 +++++++++++++++++++++
 tb/tb_vga_embarcacao_param.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_embarcacao_param.sv
// Ship renderer for one ship of 1..MAX_CELULAS cells on the 8x8 board grid of a
// 640x480 VGA frame.
//
// A carregar strobe latches the packed cell positions and the cell count. The
// pixel border table is then built one cell per clock. Once the table is
// complete, pronto is raised and every pixel that falls inside a valid cell is
// coloured.
//
// Hit cells blink white, toggling on frame starts. A fully hit (sunk) ship is
// drawn steady red. The colour and sunk outputs are registered, so they lag the
// sampled pixel by one cycle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   areaAtiva           active video area
//   linha, coluna       current VGA line / column
//   carregar            load strobe (ignored while the table is being built)
//   posicoesEmbarcacao  cell i: X = [8i+3:8i], Y = [8i+7:8i+4], valid 1..8
//   numCelulas          cells in use (clamped to MAX_CELULAS)
//   acertos             live per-cell hit mask
//   pronto              border table valid, ship being drawn
//   afundado            every used cell is hit
//   rgb_r, rgb_g, rgb_b registered colour
module vga_embarcacao_param #(
    parameter int unsigned MAX_CELULAS  = 5,
    parameter logic [2:0]  COR          = 3'b010,
    parameter int unsigned CELL_W       = 54,
    parameter int unsigned CELL_H       = 49,
    parameter int unsigned ORIGEM_X     = 16,
    parameter int unsigned ORIGEM_Y     = 16,
    parameter int unsigned PASSO_X      = 62,
    parameter int unsigned PASSO_Y      = 57,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     areaAtiva,
    input  logic [9:0]               linha,
    input  logic [9:0]               coluna,
    input  logic                     carregar,
    input  logic [8*MAX_CELULAS-1:0] posicoesEmbarcacao,
    input  logic [3:0]               numCelulas,
    input  logic [MAX_CELULAS-1:0]   acertos,
    output logic                     pronto,
    output logic                     afundado,
    output logic                     rgb_r,
    output logic                     rgb_g,
    output logic                     rgb_b
);

    localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {StOcioso, StCalcula, StPronto} state_e;

    state_e                   state_q, state_d;
    logic [3:0]               idx_q, idx_d;
    logic [8*MAX_CELULAS-1:0] pos_q, pos_d;
    logic [3:0]               ncel_q, ncel_d;
    logic [9:0]               left_q [MAX_CELULAS];
    logic [9:0]               left_d [MAX_CELULAS];
    logic [9:0]               down_q [MAX_CELULAS];
    logic [9:0]               down_d [MAX_CELULAS];
    logic [MAX_CELULAS-1:0]   valid_q, valid_d;
    logic [FrameW-1:0]        frame_q, frame_d;
    logic                     phase_q, phase_d;
    logic                     pronto_q, pronto_d;
    logic                     afundado_q, afundado_d;
    logic [2:0]               rgb_q, rgb_d;

    logic       load;
    logic [3:0] cur_x, cur_y;
    logic       found, found_hit, all_hit, sunk, frame_start;

    // A strobe is only honoured outside the table build.
    assign load = carregar && (state_q != StCalcula);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        ncel_d  = ncel_q;
        left_d  = left_q;
        down_d  = down_q;
        valid_d = valid_q;
        cur_x   = 4'd0;
        cur_y   = 4'd0;

        for (int i = 0; i < int'(MAX_CELULAS); i++) begin
            if (idx_q == 4'(i)) begin
                cur_x = pos_q[8*i +: 4];
                cur_y = pos_q[8*i+4 +: 4];
            end
        end

        case (state_q)
            StOcioso: begin
                if (carregar) state_d = StCalcula;
            end
            StCalcula: begin
                for (int i = 0; i < int'(MAX_CELULAS); i++) begin
                    if (idx_q == 4'(i)) begin
                        left_d[i]  = 10'(ORIGEM_X) + ({6'd0, cur_x} - 10'd1) * 10'(PASSO_X);
                        down_d[i]  = 10'(ORIGEM_Y) + ({6'd0, cur_y} - 10'd1) * 10'(PASSO_Y);
                        valid_d[i] = (cur_x >= 4'd1) && (cur_x <= 4'd8) &&
                                     (cur_y >= 4'd1) && (cur_y <= 4'd8) &&
                                     (4'(i) < ncel_q);
                    end
                end
                if (idx_q == 4'(MAX_CELULAS - 1)) begin
                    state_d = StPronto;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StPronto: begin
                if (carregar) state_d = StCalcula;
            end
            default: state_d = StOcioso;
        endcase

        if (load) begin
            pos_d  = posicoesEmbarcacao;
            ncel_d = (numCelulas > 4'(MAX_CELULAS)) ? 4'(MAX_CELULAS) : numCelulas;
            idx_d  = 4'd0;
        end
    end

    // Pixel hit test; the lowest-index matching cell decides the colour.
    always_comb begin
        found     = 1'b0;
        found_hit = 1'b0;
        for (int i = 0; i < int'(MAX_CELULAS); i++) begin
            if (!found && valid_q[i] &&
                (linha > down_q[i]) && (linha < down_q[i] + 10'(CELL_H)) &&
                (coluna > left_q[i]) && (coluna < left_q[i] + 10'(CELL_W))) begin
                found     = 1'b1;
                found_hit = acertos[i];
            end
        end
    end

    always_comb begin
        all_hit = 1'b1;
        for (int i = 0; i < int'(MAX_CELULAS); i++) begin
            if ((4'(i) < ncel_q) && !acertos[i]) all_hit = 1'b0;
        end
        sunk = pronto_q && (ncel_q != 4'd0) && all_hit;

        frame_start = (linha == 10'd0) && (coluna == 10'd0);
        frame_d     = frame_q;
        phase_d     = phase_q;
        if (frame_start) begin
            if (frame_q == FrameW'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end

        // pronto lags the state by one cycle and drops on the accepting edge.
        pronto_d   = (state_q == StPronto) && !carregar;
        afundado_d = sunk;

        rgb_d = 3'b000;
        if (pronto_q && areaAtiva && found) begin
            if (sunk) begin
                rgb_d = 3'b100;
            end else if (found_hit && phase_q) begin
                rgb_d = 3'b111;
            end else begin
                rgb_d = COR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StOcioso;
            idx_q      <= 4'd0;
            pos_q      <= '0;
            ncel_q     <= 4'd0;
            valid_q    <= '0;
            frame_q    <= '0;
            phase_q    <= 1'b0;
            pronto_q   <= 1'b0;
            afundado_q <= 1'b0;
            rgb_q      <= 3'b000;
            for (int i = 0; i < int'(MAX_CELULAS); i++) begin
                left_q[i] <= 10'd0;
                down_q[i] <= 10'd0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pos_q      <= pos_d;
            ncel_q     <= ncel_d;
            valid_q    <= valid_d;
            frame_q    <= frame_d;
            phase_q    <= phase_d;
            pronto_q   <= pronto_d;
            afundado_q <= afundado_d;
            rgb_q      <= rgb_d;
            left_q     <= left_d;
            down_q     <= down_d;
        end
    end

    assign pronto                = pronto_q;
    assign afundado              = afundado_q;
    assign {rgb_r, rgb_g, rgb_b} = rgb_q;

endmodule

// File: tb/tb_vga_embarcacao_param.sv
// Self-checking bench for vga_embarcacao_param (BLINK_FRAMES = 2): directed
// scenarios with literal expectations, then randomized traffic compared every
// cycle against a behavioural model of the ship renderer.
module tb_vga_embarcacao_param;

    localparam int MAXC = 5;
    localparam int CW   = 54;
    localparam int CH   = 49;
    localparam int OX   = 16;
    localparam int OY   = 16;
    localparam int PX   = 62;
    localparam int PY   = 57;
    localparam int BF   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              areaAtiva;
    logic [9:0]        linha;
    logic [9:0]        coluna;
    logic              carregar;
    logic [8*MAXC-1:0] pos;
    logic [3:0]        numCel;
    logic [MAXC-1:0]   acertos;
    wire               pronto;
    wire               afundado;
    wire               rgb_r;
    wire               rgb_g;
    wire               rgb_b;
    wire  [2:0]        rgb = {rgb_r, rgb_g, rgb_b};

    int errors = 0;
    int checks = 0;

    vga_embarcacao_param #(
        .MAX_CELULAS (MAXC),
        .COR         (3'b010),
        .CELL_W      (CW),
        .CELL_H      (CH),
        .ORIGEM_X    (OX),
        .ORIGEM_Y    (OY),
        .PASSO_X     (PX),
        .PASSO_Y     (PY),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .areaAtiva         (areaAtiva),
        .linha             (linha),
        .coluna            (coluna),
        .carregar          (carregar),
        .posicoesEmbarcacao(pos),
        .numCelulas        (numCel),
        .acertos           (acertos),
        .pronto            (pronto),
        .afundado          (afundado),
        .rgb_r             (rgb_r),
        .rgb_g             (rgb_g),
        .rgb_b             (rgb_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A load accepted at edge t makes the ship visible from edge t+MAXC+1 on;
    // loads between those edges are ignored.
    logic              m_live = 1'b0;
    logic              m_has = 1'b0;
    logic              m_pronto = 1'b0;
    logic              m_phase = 1'b0;
    int                m_frame = 0;
    int                m_t = 0;
    int                cyc = 0;
    int                m_ncel = 0;
    logic [8*MAXC-1:0] m_pos = '0;
    logic              exp_pronto = 1'b0;
    logic              exp_af = 1'b0;
    logic [2:0]        exp_rgb = 3'b000;

    always @(posedge clk) begin
        logic sunk;
        logic hit;
        logic hit_ac;
        int   x, y, lft, dwn, l, c;
        cyc++;
        if (reset) begin
            m_live = 1'b1; m_has = 1'b0; m_pronto = 1'b0; m_phase = 1'b0; m_frame = 0;
            exp_pronto = 1'b0; exp_af = 1'b0; exp_rgb = 3'b000;
        end else begin
            l = int'(linha);
            c = int'(coluna);
            sunk = m_pronto && (m_ncel > 0);
            for (int i = 0; i < m_ncel; i++) if (!acertos[i]) sunk = 1'b0;
            hit = 1'b0;
            hit_ac = 1'b0;
            for (int i = 0; i < MAXC; i++) begin
                x = int'(m_pos[8*i +: 4]);
                y = int'(m_pos[8*i+4 +: 4]);
                lft = OX + (x - 1) * PX;
                dwn = OY + (y - 1) * PY;
                if (!hit && i < m_ncel && x >= 1 && x <= 8 && y >= 1 && y <= 8 &&
                    l > dwn && l < dwn + CH && c > lft && c < lft + CW) begin
                    hit = 1'b1;
                    hit_ac = acertos[i];
                end
            end
            exp_af  = sunk;
            exp_rgb = 3'b000;
            if (m_pronto && areaAtiva && hit)
                exp_rgb = sunk ? 3'b100 : ((hit_ac && m_phase) ? 3'b111 : 3'b010);
            if (l == 0 && c == 0) begin
                if (m_frame == BF - 1) begin
                    m_frame = 0;
                    m_phase = ~m_phase;
                end else begin
                    m_frame++;
                end
            end
            if (carregar && (!m_has || cyc - m_t >= MAXC + 1)) begin
                m_has  = 1'b1;
                m_t    = cyc;
                m_pos  = pos;
                m_ncel = (int'(numCel) > MAXC) ? MAXC : int'(numCel);
            end
            m_pronto   = m_has && (cyc - m_t >= MAXC + 1);
            exp_pronto = m_pronto;
        end
    end

    // Single compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_live) begin
            check("pronto_model", {2'b00, pronto}, {2'b00, exp_pronto});
            check("afundado_model", {2'b00, afundado}, {2'b00, exp_af});
            check("rgb_model", rgb, exp_rgb);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pix(input int l, input int c, input logic a, input logic [2:0] e,
                       input string nm);
        @(negedge clk);
        linha = 10'(l); coluna = 10'(c); areaAtiva = a;
        @(negedge clk);
        check(nm, rgb, e);
    endtask

    task automatic load(input logic [8*MAXC-1:0] p, input int n);
        @(negedge clk);
        pos = p; numCel = 4'(n); carregar = 1'b1;
        @(negedge clk);
        carregar = 1'b0;
    endtask

    task automatic frame_start();
        @(negedge clk);
        linha = 10'd0; coluna = 10'd0;
        @(negedge clk);
        linha = 10'd500; coluna = 10'd700;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [8*MAXC-1:0] rand_pos();
        logic [8*MAXC-1:0] p;
        logic [3:0] v;
        for (int i = 0; i < 2 * MAXC; i++) begin
            case ($urandom_range(0, 9))
                0:       v = 4'd0;
                1:       v = ($urandom_range(0, 1) == 0) ? 4'd9 : 4'd15;
                default: v = 4'($urandom_range(1, 8));
            endcase
            p[4*i +: 4] = v;
        end
        return p;
    endfunction

    localparam logic [8*MAXC-1:0] Cells3 = {8'h00, 8'h00, 8'h13, 8'h12, 8'h11};

    initial begin
        int j, x, y;
        logic [2:0] e;
        reset = 1'b1; carregar = 1'b0; areaAtiva = 1'b0;
        linha = 10'd500; coluna = 10'd700;
        acertos = '0; pos = '0; numCel = 4'd0;
        repeat (2) @(negedge clk);
        check("reset_pronto", {2'b00, pronto}, 3'b000);
        check("reset_afundado", {2'b00, afundado}, 3'b000);
        check("reset_rgb", rgb, 3'b000);
        reset = 1'b0;

        // Load latency and first pixels.
        load(Cells3, 3);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("pronto_latency", {2'b00, pronto}, {2'b00, (k == 6)});
        end
        pix(40, 50, 1'b1, 3'b010, "cell11_inside");
        pix(40, 16, 1'b1, 3'b000, "cell11_left_edge");
        pix(65, 50, 1'b1, 3'b000, "cell11_top_edge");

        // Corner cell (8,8) boundaries.
        load({32'h0, 8'h88}, 1);
        repeat (6) @(negedge clk);
        pix(416, 451, 1'b1, 3'b010, "cell88_low_corner");
        pix(463, 503, 1'b1, 3'b010, "cell88_high_corner");
        pix(415, 451, 1'b1, 3'b000, "cell88_below");
        pix(416, 504, 1'b1, 3'b000, "cell88_right");
        pix(440, 470, 1'b0, 3'b000, "cell88_inactive");

        // Blinking of a single hit cell.
        pulse_reset();
        acertos = 5'b00010;
        load(Cells3, 3);
        repeat (6) @(negedge clk);
        pix(40, 100, 1'b1, 3'b010, "blink_c1_f0");
        for (int f = 1; f <= 4; f++) begin
            frame_start();
            e = (((f / 2) % 2) == 1) ? 3'b111 : 3'b010;
            pix(40, 100, 1'b1, e, "blink_c1");
            pix(40, 50, 1'b1, 3'b010, "blink_c0_steady");
            pix(40, 160, 1'b1, 3'b010, "blink_c2_steady");
        end

        // Sunk and recovery.
        acertos = 5'b00111;
        pix(40, 50, 1'b1, 3'b100, "sunk_c0_red");
        check("sunk_afundado", {2'b00, afundado}, 3'b001);
        pix(40, 100, 1'b1, 3'b100, "sunk_c1_red");
        pix(40, 160, 1'b1, 3'b100, "sunk_c2_red");
        acertos = 5'b00110;
        pix(40, 50, 1'b1, 3'b010, "unsunk_c0_green");
        check("unsunk_afundado", {2'b00, afundado}, 3'b000);

        // Invalid coordinates still count toward sinking.
        load({8'h00, 8'h00, 8'h13, 8'h92, 8'h10}, 3);
        repeat (6) @(negedge clk);
        acertos = 5'b00100;
        pix(40, 50, 1'b1, 3'b000, "x0_not_drawn");
        pix(475, 100, 1'b1, 3'b000, "y9_not_drawn");
        pix(40, 160, 1'b1, 3'b010, "valid_c2_green");
        check("invalid_not_sunk", {2'b00, afundado}, 3'b000);
        acertos = 5'b00111;
        pix(40, 160, 1'b1, 3'b100, "invalid_sunk_red");
        check("invalid_sunk", {2'b00, afundado}, 3'b001);

        // Zero cells.
        load(Cells3, 0);
        repeat (6) @(negedge clk);
        acertos = 5'b11111;
        pix(40, 50, 1'b1, 3'b000, "ncel0_not_drawn");
        check("ncel0_not_sunk", {2'b00, afundado}, 3'b000);

        // Strobe during the build is ignored.
        acertos = '0;
        load(Cells3, 3);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("pronto_ignore_reload", {2'b00, pronto}, {2'b00, (k == 6)});
            carregar = (k == 1);
        end
        carregar = 1'b0;

        // Reset during the build.
        load(Cells3, 3);
        @(negedge clk);
        pulse_reset();
        check("midcalc_reset_pronto", {2'b00, pronto}, 3'b000);
        check("midcalc_reset_rgb", rgb, 3'b000);
        repeat (8) @(negedge clk);
        check("midcalc_stays_idle", {2'b00, pronto}, 3'b000);
        load(Cells3, 3);
        repeat (6) @(negedge clk);
        pix(40, 50, 1'b1, 3'b010, "reload_after_reset");

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            reset    = ($urandom_range(0, 399) == 0);
            carregar = ($urandom_range(0, 39) == 0);
            if (carregar) begin
                pos    = rand_pos();
                numCel = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 19) == 0)
                acertos = ($urandom_range(0, 2) == 0) ? '1 : MAXC'($urandom);
            areaAtiva = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 9))
                0: begin linha = 10'd0; coluna = 10'd0; end
                1, 2: begin
                    linha  = 10'($urandom_range(0, 479));
                    coluna = 10'($urandom_range(0, 639));
                end
                default: begin
                    j = $urandom_range(0, MAXC - 1);
                    x = int'(m_pos[8*j +: 4]);
                    y = int'(m_pos[8*j+4 +: 4]);
                    if (x < 1 || x > 8) x = $urandom_range(1, 8);
                    if (y < 1 || y > 8) y = $urandom_range(1, 8);
                    linha  = 10'(OY + (y - 1) * PY + $urandom_range(0, 50));
                    coluna = 10'(OX + (x - 1) * PX + $urandom_range(0, 55));
                end
            endcase
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
